// File: rtl/ram_burst_reader.sv
// Streams a burst of consecutive words out of a synchronous-read RAM through a
// 2-entry skid FIFO with valid/ready backpressure on the output side.
module ram_burst_reader #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   length,
  output logic [ADDR_W-1:0] ram_raddr,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_e;

  localparam logic [ADDR_W:0]   MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ADR_ONE = ADDR_W'(1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   rd_left_q, rd_left_d;
  logic [ADDR_W:0]   beat_left_q, beat_left_d;
  logic [ADDR_W-1:0] raddr_q;
  logic              inflight_q;
  logic              done_q, done_d;

  logic [DATA_W-1:0] fifo_q [2];
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        cnt_q, cnt_d;

  logic [ADDR_W:0]   len_sat;
  logic              push, pop, issue;
  logic [2:0]        occ;

  assign len_sat   = (length > MAX_LEN) ? MAX_LEN : length;
  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = out_valid ? fifo_q[rd_ptr_q] : '0;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

  assign pop  = out_valid & out_ready;
  assign push = inflight_q;
  // Count the word already in flight so the FIFO can never be over-subscribed.
  assign occ   = {1'b0, cnt_q} + {2'b00, inflight_q};
  assign issue = (state_q == READ) && (rd_left_q != '0)
                 && ((occ - {2'b00, pop}) < 3'd2);

  // The RAM address is held between issues so the RAM sees a stable port.
  assign ram_raddr = issue ? addr_q : raddr_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rd_left_d   = rd_left_q;
    beat_left_d = beat_left_q;
    done_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          addr_d      = start_addr;
          rd_left_d   = len_sat;
          beat_left_d = len_sat;
          if (len_sat == '0) done_d  = 1'b1;
          else               state_d = READ;
        end
      end
      READ: begin
        if (issue) begin
          addr_d    = addr_q + ADR_ONE;
          rd_left_d = rd_left_q - CNT_ONE;
          if (rd_left_q == CNT_ONE) state_d = DRAIN;
        end
        if (pop) beat_left_d = beat_left_q - CNT_ONE;
      end
      DRAIN: begin
        if (pop) begin
          beat_left_d = beat_left_q - CNT_ONE;
          if (beat_left_q == CNT_ONE) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rd_left_q   <= '0;
      beat_left_q <= '0;
      raddr_q     <= '0;
      inflight_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rd_left_q   <= rd_left_d;
      beat_left_q <= beat_left_d;
      raddr_q     <= ram_raddr;
      inflight_q  <= issue;
      done_q      <= done_d;
    end
  end

  // Data captured exactly one cycle after issue, matching the RAM read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      cnt_q     <= 2'd0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= ram_rdata;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_ram_burst_reader.sv
// Burst reader bench: directed and random bursts against a queue-based model
// of the expected word stream built directly from the RAM image.
module tb_ram_burst_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [5:0] start_addr;
  logic [6:0] length;
  logic [5:0] ram_raddr;
  logic [7:0] ram_rdata;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       done;

  logic [7:0] mem [64];
  logic [7:0] expq [$];
  int vectors = 0;
  int errors  = 0;

  ram_burst_reader #(.DATA_W(8), .ADDR_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
    .length(length), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ram_rdata <= mem[ram_raddr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Caller must be just past a negedge when wait_neg is 0 (back-to-back start).
  task automatic run_burst(input int a, input int l, input int mode,
                           input bit wait_neg, input bit poke, input int abort_at);
    int lsat, beats, first_v, c;
    bit seen_done, prev_stall;
    logic [7:0] prev_data, e;
    lsat = (l > 64) ? 64 : l;
    expq.delete();
    for (int i = 0; i < lsat; i++) expq.push_back(mem[(a + i) % 64]);
    if (wait_neg) @(negedge clk);
    start = 1'b1; start_addr = 6'(a); length = 7'(l); out_ready = 1'b1;
    #1;
    chk("busy_c0", busy, 0);
    beats = 0; first_v = -1; prev_stall = 0; seen_done = 0; prev_data = '0;
    for (c = 1; c <= 600 && !seen_done; c++) begin
      @(negedge clk);
      start = poke && (c == 2);
      if (poke && c == 2) start_addr = 6'($urandom);
      out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (c % 3 == 1) : ($urandom % 3 != 0);
      #1;
      if (c == 1 && lsat > 0) begin
        chk("raddr_c1", ram_raddr, a % 64);
        chk("busy_c1", busy, 1);
      end
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, prev_data);
      end
      if (out_valid && first_v < 0) begin
        first_v = c;
        if (mode == 0) chk("first_valid_cyc", c, 3);
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) chk("extra_beat", out_valid, 0);
        else begin
          e = expq.pop_front();
          chk("beat", out_data, e);
        end
        beats++;
        if (abort_at > 0 && beats == abort_at) begin
          @(negedge clk); rst = 1'b1; #1;
          @(negedge clk); rst = 1'b0; #1;
          chk("abort_valid", out_valid, 0);
          chk("abort_busy", busy, 0);
          chk("abort_done", done, 0);
          chk("abort_raddr", ram_raddr, 0);
          chk("abort_data", out_data, 0);
          repeat (6) begin
            @(negedge clk); #1;
            chk("post_abort_valid", out_valid, 0);
            chk("post_abort_done", done, 0);
          end
          expq.delete();
          start = 1'b0;
          return;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (done) begin
        seen_done = 1;
        chk("done_busy", busy, 0);
        chk("beat_count", beats, lsat);
        if (mode == 0) chk("done_cyc", c, (lsat == 0) ? 1 : lsat + 3);
      end
    end
    chk("timeout", seen_done, 1);
    if (lsat == 0) chk("len0_no_valid", first_v, -1);
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start_addr = '0; length = '0; out_ready = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 8'(i + 16);
    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_raddr", ram_raddr, 0);
    chk("rst_data", out_data, 0);
    rst = 1'b0;

    run_burst(5, 4, 0, 1, 0, 0);
    run_burst(62, 4, 0, 1, 0, 0);
    run_burst(10, 8, 1, 1, 0, 0);
    run_burst(20, 0, 0, 1, 0, 0);
    run_burst(0, 100, 0, 1, 0, 0);
    run_burst(3, 10, 0, 1, 0, 2);
    run_burst(7, 6, 0, 1, 0, 0);
    run_burst(30, 8, 0, 1, 1, 0);
    run_burst(40, 5, 0, 0, 0, 0);

    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
      run_burst($urandom % 64, $urandom % 80, 2, ($urandom % 2) == 0, ($urandom % 4) == 0, 0);
    end

    @(negedge clk); #1;
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/ram_burst_reader.md
RAM_BURST_READER -- requirements
Module: ram_burst_reader

Interface
REQ-001 The block SHALL take parameter DATA_W, default 8: RAM word width.
REQ-002 The block SHALL take parameter ADDR_W, default 6: RAM address width (depth 2**ADDR_W = 64).
REQ-003 The block SHALL have port clk, input, width 1: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, width 1: synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, width 1: burst request, sampled only in IDLE.
REQ-006 The block SHALL have port start_addr, input, width ADDR_W: first RAM address of the burst.
REQ-007 The block SHALL have port length, input, width ADDR_W+1: word count; 0 = empty burst, values >64 saturate to 64.
REQ-008 The block SHALL have port ram_raddr, output, width ADDR_W: read address to the RAM.
REQ-009 The block SHALL have port ram_rdata, input, width DATA_W: RAM read data, registered by the RAM one cycle after ram_raddr.
REQ-010 The block SHALL have port out_data, output, width DATA_W: streamed word.
REQ-011 The block SHALL have port out_valid, output, width 1: out_data holds a valid word.
REQ-012 The block SHALL have port out_ready, input, width 1: sink accepts; a beat transfers when out_valid and out_ready are both high at a rising edge.
REQ-013 The block SHALL have port busy, output, width 1: high from start acceptance until done.
REQ-014 The block SHALL have port done, output, width 1: one-cycle pulse at burst end.

Function
REQ-015 The FSM SHALL have states IDLE, READ and DRAIN; transitions are IDLE->READ on start, READ->DRAIN after the last read issue, and DRAIN->IDLE after the last beat transfers.
REQ-016 In IDLE with start high, start_addr and the saturated length SHALL be latched, busy SHALL go high the next cycle, and a length of 0 SHALL give done the next cycle with no reads and no beats.
REQ-017 A read issue SHALL drive ram_raddr with the current address and post-increment it modulo 64, so address 63 wraps to 0.
REQ-018 Output buffering SHALL be a 2-entry FIFO, and a read SHALL issue only when occupancy + in-flight reads - (pop this cycle) < 2, so the buffer never overflows.
REQ-019 Each in-flight read SHALL capture ram_rdata into the FIFO exactly one cycle after issue.
REQ-020 With start in cycle 0, ram_raddr SHALL equal start_addr in cycle 1, out_valid SHALL first rise in cycle 3, and with out_ready held high one beat SHALL transfer per cycle with no bubbles.
REQ-021 While out_valid is high and out_ready is low, out_data and out_valid SHALL hold stable.
REQ-022 Beats SHALL appear in address order with no loss or duplication, exactly length beats per burst.
REQ-023 done SHALL pulse for one cycle in the cycle after the final beat transfers, busy SHALL be low in that same cycle, and the FSM SHALL be in IDLE.
REQ-024 start SHALL be ignored while busy, and start in the done cycle SHALL be accepted.
REQ-025 ram_raddr SHALL hold its last value when no read is issuing.

Reset
REQ-026 With rst high at a rising edge, the FSM SHALL go to IDLE, the FIFO and in-flight count SHALL clear, and out_valid=0, busy=0, done=0, ram_raddr=0, out_data=0.
REQ-027 rst SHALL take precedence over start and over any handshake in the same cycle.
REQ-028 A reset mid-burst SHALL abort the burst with no done pulse, and no stale word SHALL appear afterwards.

Verification
REQ-029 The bench SHALL cover: RAM[i]=i+0x10; start_addr=5, length=4, out_ready=1 -> ram_raddr=5 in cycle 1; beats 0x15,0x16,0x17,0x18 in cycles 3-6; done in cycle 7.
REQ-030 The bench SHALL cover: start_addr=62, length=4 -> beats from addresses 62,63,0,1 (wrap).
REQ-031 The bench SHALL cover: length=8 with out_ready toggling 1,0,0,1,... -> 8 correct in-order beats, out_data stable while stalled, no overflow.
REQ-032 The bench SHALL cover: length=0 -> done one cycle after start, out_valid never high; length=100 -> exactly 64 beats.
REQ-033 The bench SHALL cover: rst asserted after beat 2 of a length-10 burst -> all outputs 0 next cycle, no done; a new burst started afterwards completes correctly.
REQ-034 The bench SHALL cover: start pulsed while busy -> ignored; start in the done cycle -> second burst accepted back-to-back.
